// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: state encodings, default widths and
// the "no best time yet" marker.
package maze_pkg;

    localparam int MAZE_COORD_W = 4;
    localparam int MAZE_TIME_W  = 10;

    // best_sec holds all ones until a run has been completed
    localparam logic [MAZE_TIME_W-1:0] BEST_NONE = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CARVE_REQ = 3'd1,
        ST_CARVING   = 3'd2,
        ST_PLAY      = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

endpackage

// File: rtl/maze_game_sequencer_sec_tick_gen.sv
// Seconds prescaler: counts enabled cycles 0..TICKS_PER_SEC-1 and flags the wrap
// cycle with a one-cycle tick. clr restarts the second from zero.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign tick = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/maze_game_sequencer.sv
// Top-level maze game controller: kicks off the carver, runs and times the
// player's attempt, detects arrival at the finish tile and keeps the best time.
module maze_game_sequencer
    import maze_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int COORD_W       = MAZE_COORD_W,
    parameter int TIME_W        = MAZE_TIME_W,
    parameter int CARVE_TIMEOUT = 100_000_000,
    parameter int WIN_HOLD_SEC  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               carve_done,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    input  logic [COORD_W-1:0] finish_x,
    input  logic [COORD_W-1:0] finish_y,
    output logic               carve_start,
    output logic               carve_active,
    output logic               move_enable,
    output logic               win,
    output logic               carve_error,
    output logic [TIME_W-1:0]  elapsed_sec,
    output logic [TIME_W-1:0]  best_sec,
    output logic [2:0]         state
);

    localparam int TMO_W  = (CARVE_TIMEOUT > 1) ? $clog2(CARVE_TIMEOUT) : 1;
    localparam int HOLD_W = $clog2(WIN_HOLD_SEC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CARVE_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD_SEC - 1);

    state_t             state_reg, state_next;
    logic [TMO_W-1:0]   tmo_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [TIME_W-1:0]  elapsed_reg, best_reg;
    logic               carve_error_reg;
    logic               carve_start_reg, carve_active_reg, move_enable_reg, win_reg;
    logic               tick, at_finish, carve_timeout, hold_done, tick_clr, tick_en;

    assign at_finish     = (char_x == finish_x) && (char_y == finish_y);
    assign carve_timeout = (tmo_reg == TMO_LAST);
    assign hold_done     = tick && (hold_reg == HOLD_LAST);

    // Every state change restarts the second, so WIN is held for whole seconds
    assign tick_clr = (state_next != state_reg);
    assign tick_en  = (state_reg == ST_PLAY) || (state_reg == ST_WIN);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:      state_next = new_game ? ST_CARVE_REQ : ST_IDLE;
            ST_CARVE_REQ: state_next = ST_CARVING;
            ST_CARVING: begin
                if (carve_done)         state_next = ST_PLAY;
                else if (carve_timeout) state_next = ST_IDLE;
                else                    state_next = ST_CARVING;
            end
            ST_PLAY: begin
                if (at_finish)     state_next = ST_WIN;
                else if (new_game) state_next = ST_CARVE_REQ;
                else               state_next = ST_PLAY;
            end
            ST_WIN: begin
                if (new_game)       state_next = ST_CARVE_REQ;
                else if (hold_done) state_next = ST_IDLE;
                else                state_next = ST_WIN;
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // Enables are decoded from the next state so they line up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            tmo_reg          <= '0;
            hold_reg         <= '0;
            elapsed_reg      <= '0;
            best_reg         <= '1;
            carve_error_reg  <= 1'b0;
            carve_start_reg  <= 1'b0;
            carve_active_reg <= 1'b0;
            move_enable_reg  <= 1'b0;
            win_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            carve_start_reg  <= (state_next == ST_CARVE_REQ);
            carve_active_reg <= (state_next == ST_CARVING);
            move_enable_reg  <= (state_next == ST_PLAY);
            win_reg          <= (state_next == ST_WIN);

            tmo_reg  <= (state_reg == ST_CARVING) ? tmo_reg + 1'b1 : '0;
            hold_reg <= (state_reg != ST_WIN) ? '0 : (tick ? hold_reg + 1'b1 : hold_reg);

            if (state_next == ST_CARVE_REQ) begin
                carve_error_reg <= 1'b0;
            end else if (state_reg == ST_CARVING && !carve_done && carve_timeout) begin
                carve_error_reg <= 1'b1;
            end

            if (state_next == ST_CARVE_REQ) begin
                elapsed_reg <= '0;
            end else if (state_reg == ST_PLAY && state_next == ST_PLAY && tick
                         && elapsed_reg != '1) begin
                elapsed_reg <= elapsed_reg + 1'b1;
            end

            if (state_reg == ST_PLAY && at_finish && elapsed_reg < best_reg) begin
                best_reg <= elapsed_reg;
            end
        end
    end

    assign carve_start  = carve_start_reg;
    assign carve_active = carve_active_reg;
    assign move_enable  = move_enable_reg;
    assign win          = win_reg;
    assign carve_error  = carve_error_reg;
    assign elapsed_sec  = elapsed_reg;
    assign best_sec     = best_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_maze_game_sequencer.sv
// Directed bench for maze_game_sequencer: a cycle model pushes the expected
// output vector each cycle, and key scenario values are checked as constants.
module tb_maze_game_sequencer;
    import maze_pkg::*;

    localparam int TPS  = 10;
    localparam int CT   = 50;
    localparam int HOLD = 2;
    localparam int CW   = 4;
    localparam int TW   = 10;

    logic          clk = 1'b0;
    logic          reset, new_game, carve_done;
    logic [CW-1:0] char_x, char_y, finish_x, finish_y;
    logic          carve_start, carve_active, move_enable, win, carve_error;
    logic [TW-1:0] elapsed_sec, best_sec;
    logic [2:0]    state;

    typedef struct packed {
        logic [2:0]    st;
        logic          cs;
        logic          ca;
        logic          me;
        logic          w;
        logic          ce;
        logic [TW-1:0] el;
        logic [TW-1:0] be;
    } obs_t;

    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    int            m_state, m_pre, m_tmo, m_hold;
    logic [TW-1:0] m_el, m_be;
    logic          m_err;

    always #5 clk = ~clk;

    maze_game_sequencer #(
        .TICKS_PER_SEC(TPS),
        .COORD_W      (CW),
        .TIME_W       (TW),
        .CARVE_TIMEOUT(CT),
        .WIN_HOLD_SEC (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .carve_done  (carve_done),
        .char_x      (char_x),
        .char_y      (char_y),
        .finish_x    (finish_x),
        .finish_y    (finish_y),
        .carve_start (carve_start),
        .carve_active(carve_active),
        .move_enable (move_enable),
        .win         (win),
        .carve_error (carve_error),
        .elapsed_sec (elapsed_sec),
        .best_sec    (best_sec),
        .state       (state)
    );

    function automatic obs_t observed();
        obs_t o;
        o = {state, carve_start, carve_active, move_enable, win, carve_error,
             elapsed_sec, best_sec};
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o = {3'(m_state), (m_state == 1), (m_state == 2), (m_state == 3),
             (m_state == 4), m_err, m_el, m_be};
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_tmo = 0; m_hold = 0;
        m_el = '0; m_be = '1; m_err = 1'b0;
    endtask

    task automatic model_step();
        logic match, tick;
        int   ns;
        match = (char_x == finish_x) && (char_y == finish_y);
        tick  = (m_state == 3 || m_state == 4) && (m_pre == TPS - 1);
        ns    = m_state;
        case (m_state)
            0: if (new_game) ns = 1;
            1: ns = 2;
            2: if (carve_done) ns = 3; else if (m_tmo == CT - 1) ns = 0;
            3: if (match) ns = 4; else if (new_game) ns = 1;
            4: if (new_game) ns = 1; else if (tick && m_hold == HOLD - 1) ns = 0;
            default: ns = 0;
        endcase
        if (ns == 1) m_err = 1'b0;
        else if (m_state == 2 && ns == 0) m_err = 1'b1;
        if (m_state == 3 && match && m_el < m_be) m_be = m_el;
        if (ns == 1) m_el = '0;
        else if (m_state == 3 && ns == 3 && tick && m_el != '1) m_el = m_el + 1'b1;
        m_hold = (m_state == 4) ? m_hold + int'(tick) : 0;
        m_tmo  = (m_state == 2) ? m_tmo + 1 : 0;
        if (ns != m_state) m_pre = 0;
        else if (m_state == 3 || m_state == 4) m_pre = (m_pre == TPS - 1) ? 0 : m_pre + 1;
        m_state = ns;
    endtask

    task automatic step();
        obs_t e, o;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0t: observed %h expected %h", phase, $time, o, e);
        end
        $display("cycle %-8s t=%0t state=%0d cs=%b ca=%b me=%b win=%b err=%b el=%0d best=%0d",
                 phase, $time, state, carve_start, carve_active, move_enable, win,
                 carve_error, elapsed_sec, best_sec);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; carve_done = 1'b0;
        char_x = 4'd1; char_y = 4'd1; finish_x = 4'd3; finish_y = 4'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 0);
        chk("reset_outs", 32'({carve_start, carve_active, move_enable, win, carve_error}), 0);
        chk("reset_elapsed", 32'(elapsed_sec), 0);
        chk("reset_best", 32'(best_sec), 32'(BEST_NONE));
        reset = 1'b0;

        // Scenario 1: start pulse and carving
        phase = "idle";    steps(4);
        phase = "req";     new_game = 1'b1; step(); new_game = 1'b0;
        chk("carve_start_pulse", 32'(carve_start), 1);
        chk("state_req", 32'(state), 1);
        phase = "carving"; step();
        chk("carve_active", 32'(carve_active), 1);
        chk("carve_start_low", 32'(carve_start), 0);
        steps(19);

        // Scenario 2: play timing
        phase = "done";    carve_done = 1'b1; step(); carve_done = 1'b0;
        chk("move_enable", 32'(move_enable), 1);
        phase = "play";    steps(35);
        chk("elapsed_35", 32'(elapsed_sec), 3);

        // Scenario 3: finish on the 4th tick cycle
        steps(4);
        phase = "finish";  char_x = 4'd3; char_y = 4'd5; step(); char_x = 4'd1; char_y = 4'd1;
        chk("win_state", 32'(state), 4);
        chk("win_elapsed", 32'(elapsed_sec), 3);
        chk("win_best", 32'(best_sec), 3);
        phase = "win";     steps(3);
        phase = "restart"; new_game = 1'b1; step(); new_game = 1'b0;
        chk("win_restart", 32'(state), 1);
        phase = "carving"; steps(5);
        phase = "done";    carve_done = 1'b1; step(); carve_done = 1'b0;
        phase = "play";    steps(70);
        chk("elapsed_70", 32'(elapsed_sec), 7);
        phase = "finish";  char_x = 4'd3; char_y = 4'd5; step(); char_x = 4'd1; char_y = 4'd1;
        chk("slow_elapsed", 32'(elapsed_sec), 7);
        chk("best_kept", 32'(best_sec), 3);

        // Scenario 4: carve timeout
        phase = "req";     new_game = 1'b1; step(); new_game = 1'b0;
        phase = "timeout"; steps(50);
        chk("still_carving", 32'(state), 2);
        step();
        chk("timeout_idle", 32'(state), 0);
        chk("timeout_err", 32'(carve_error), 1);
        phase = "idle";    steps(3);
        phase = "req";     new_game = 1'b1; step(); new_game = 1'b0;
        chk("err_cleared", 32'(carve_error), 0);

        // Scenario 5: finish beats new_game, then WIN hold expiry
        phase = "carving"; steps(3);
        phase = "done";    carve_done = 1'b1; step(); carve_done = 1'b0;
        phase = "play";    steps(15);
        phase = "both";    new_game = 1'b1; char_x = 4'd3; char_y = 4'd5; step();
        new_game = 1'b0; char_x = 4'd1; char_y = 4'd1;
        chk("both_win", 32'(state), 4);
        chk("both_best", 32'(best_sec), 1);
        phase = "hold";    steps(19);
        chk("hold_win", 32'(win), 1);
        step();
        chk("hold_idle", 32'(state), 0);
        chk("hold_win_low", 32'(win), 0);

        // Scenario 6: async reset mid-PLAY
        phase = "req";     new_game = 1'b1; step(); new_game = 1'b0;
        phase = "carving"; step();
        phase = "done";    carve_done = 1'b1; step(); carve_done = 1'b0;
        phase = "play";    steps(45);
        chk("pre_reset_elapsed", 32'(elapsed_sec), 4);
        reset = 1'b1;
        #1;
        chk("areset_state", 32'(state), 0);
        chk("areset_outs", 32'({carve_start, carve_active, move_enable, win, carve_error}), 0);
        chk("areset_elapsed", 32'(elapsed_sec), 0);
        chk("areset_best", 32'(best_sec), 32'(BEST_NONE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        phase = "idle";    steps(2);
        phase = "req";     new_game = 1'b1; step(); new_game = 1'b0;
        chk("post_reset_start", 32'(carve_start), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
